// File: rtl/serial_fa_adder_if.sv
// Operand/result handshake bundle for the bit-serial full-adder sequencer.
// The slave side is the adder; the master side is whoever supplies operands and takes results.
interface serial_fa_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_fa_adder.sv
// Bit-serial adder: sequences one full-adder cell LSB-first over WIDTH clocks and
// returns sum, carry-out and signed overflow through a valid/ready handshake.
module serial_fa_adder #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_fa_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Returns {carry, sum} of a one-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Only WIDTH-1 sum bits need storing; the MSB comes straight from the cell on the last step.
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       fa;
  logic             fa_s;
  logic             fa_c;

  assign fa   = full_add(a_sr_q[0], b_sr_q[0], carry_q);
  assign fa_s = fa[0];
  assign fa_c = fa[1];

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = (WIDTH-1)'({fa_s, s_sr_q} >> 1);
        carry_d = fa_c;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, fa_c the carry out of it.
          sum_d   = {fa_s, s_sr_q};
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Directed bench for serial_fa_adder: one task per scenario with inline expected values.
module tb_serial_fa_adder;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_fa_adder_if #(.WIDTH(WIDTH)) bus();

  serial_fa_adder #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Drives one operation with out_ready high and returns the result and the
  // number of negedges from the one after accept until out_valid is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] s, output logic c, output logic o, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s = bus.sum;
    c = bus.cout;
    o = bus.ovf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int run_cnt;
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'h3C; bus.b = 8'h0F; bus.cin = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_drop got %b want 0", bus.in_ready); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bus.busy); end
    run_cnt = 0;
    guard = 0;
    while (bus.busy && guard < 40) begin
      run_cnt++;
      @(negedge clk);
      guard++;
    end
    checks++; if (run_cnt !== 8) begin errors++; $display("FAIL basic_run_cycles got %0d want 8", run_cnt); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.sum !== 8'h4B) begin errors++; $display("FAIL basic_sum got %h want 4b", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL basic_cout got %b want 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", bus.ovf); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_idle got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", bus.out_valid); end
  endtask

  task automatic test_carry();
    logic [7:0] s; logic c, o; int lat;
    run_op(8'hFF, 8'h01, 1'b0, s, c, o, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL carry1_latency got %0d want 8", lat); end
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL carry1_sum got %h want 00", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry1_cout got %b want 1", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL carry1_ovf got %b want 0", o); end
    run_op(8'hFF, 8'hFF, 1'b1, s, c, o, lat);
    checks++; if (s !== 8'hFF) begin errors++; $display("FAIL carry2_sum got %h want ff", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL carry2_cout got %b want 1", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL carry2_ovf got %b want 0", o); end
  endtask

  task automatic test_overflow();
    logic [7:0] s; logic c, o; int lat;
    run_op(8'h7F, 8'h01, 1'b0, s, c, o, lat);
    checks++; if (s !== 8'h80) begin errors++; $display("FAIL ovf1_sum got %h want 80", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL ovf1_cout got %b want 0", c); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got %b want 1", o); end
    run_op(8'h80, 8'h80, 1'b0, s, c, o, lat);
    checks++; if (s !== 8'h00) begin errors++; $display("FAIL ovf2_sum got %h want 00", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ovf2_cout got %b want 1", c); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf2_ovf got %b want 1", o); end
  endtask

  task automatic test_backpressure();
    logic [7:0] s; logic c, o; int lat;
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", k, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, bus.in_ready); end
      checks++; if (bus.sum !== 8'h46) begin errors++; $display("FAIL bp_sum[%0d] got %h want 46", k, bus.sum); end
      checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL bp_cout[%0d] got %b want 0", k, bus.cout); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf[%0d] got %b want 0", k, bus.ovf); end
      if (k == 1) begin
        bus.in_valid = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
      end
      if (k == 3) bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.sum !== 8'h46) begin errors++; $display("FAIL bp_sum_persist got %h want 46", bus.sum); end
    run_op(8'h01, 8'h01, 1'b0, s, c, o, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_next_latency got %0d want 8", lat); end
    checks++; if (s !== 8'h02) begin errors++; $display("FAIL bp_next_sum got %h want 02", s); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] s; logic c, o; int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL mid_rst_sum got %h want 00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL mid_rst_cout got %b want 0", bus.cout); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h01, 8'h02, 1'b0, s, c, o, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL mid_rst_next_latency got %0d want 8", lat); end
    checks++; if (s !== 8'h03) begin errors++; $display("FAIL mid_rst_next_sum got %h want 03", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL mid_rst_next_cout got %b want 0", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL mid_rst_next_ovf got %b want 0", o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta, tb_, exp_s;
    logic       tc, exp_c, exp_o;
    logic [8:0] full;
    int         acc_t, prev_t, guard;
    prev_t = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      guard = 0;
      while (!bus.in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      ta  = 8'($urandom);
      tb_ = 8'($urandom);
      tc  = 1'($urandom);
      bus.in_valid = 1'b1; bus.a = ta; bus.b = tb_; bus.cin = tc;
      acc_t = cyc;
      if (i > 0) begin
        checks++; if (acc_t - prev_t !== WIDTH + 2) begin errors++; $display("FAIL b2b_interval[%0d] got %0d want %0d", i, acc_t - prev_t, WIDTH + 2); end
      end
      prev_t = acc_t;
      full  = {1'b0, ta} + {1'b0, tb_} + {8'h00, tc};
      exp_s = full[7:0];
      exp_c = full[8];
      exp_o = (ta[7] == tb_[7]) && (full[7] != ta[7]);
      @(negedge clk);
      guard = 0;
      while (!bus.out_valid && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      checks++; if (bus.sum !== exp_s) begin errors++; $display("FAIL b2b_sum[%0d] a=%h b=%h cin=%b got %h want %h", i, ta, tb_, tc, bus.sum, exp_s); end
      checks++; if (bus.cout !== exp_c) begin errors++; $display("FAIL b2b_cout[%0d] got %b want %b", i, bus.cout, exp_c); end
      checks++; if (bus.ovf !== exp_o) begin errors++; $display("FAIL b2b_ovf[%0d] got %b want %b", i, bus.ovf, exp_o); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_fa_adder.md
Name: serial_fa_adder

Overview:
- Bit-serial adder built around a single one-bit full-adder cell. Sum bit = A^B^C; carry = majority(A,B,C).
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Feeds the full-adder cell one bit pair per clock, LSB first, and returns the WIDTH-bit sum, carry-out and signed overflow through a second valid/ready handshake.
- Sits directly upstream of the combinational full-adder cell: it is the sequencing stage that drives that cell and collects its outputs.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on a, b, cin.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous, applied at any time including mid-operation):
  - State goes to IDLE.
  - Shift registers, carry register and bit counter clear to 0.
  - Outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Any operation in progress is discarded.
- States IDLE, RUN, DONE; encoding is free.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a rising edge with in_valid=1: latch a into A_sr, b into B_sr, cin into carry register; clear the counter; go to RUN.
- RUN:
  - in_ready=0, busy=1; in_valid is ignored.
  - Each edge:
    - fa_s/fa_c = full_add(A_sr[0], B_sr[0], carry).
    - S_sr shifts right with fa_s entering at the MSB.
    - A_sr and B_sr shift right.
    - carry <= fa_c.
    - counter increments.
  - On the edge where counter == WIDTH-1:
    - capture the carry entering that bit (current carry register) into cin_msb;
    - go to DONE.
  - RUN therefore lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1, in_ready=0, busy=0.
  - sum = S_sr; cout = carry; ovf = cin_msb ^ carry.
  - Values are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
- Output values persist after leaving DONE until the next result overwrites them. Only out_valid qualifies them.
- Latency: operand accept at edge T gives out_valid=1 in the cycle following edge T+WIDTH. Minimum issue interval is WIDTH+2 cycles: DONE and IDLE each occupy at least one cycle, and there is no accept in the DONE→IDLE cycle.
- Simultaneous events: out_ready asserted in IDLE or RUN has no effect.
- Wrap-around: a sum of 2^WIDTH or more sets cout=1, and sum keeps the low WIDTH bits.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps within an operation.

Test Plan:
- Reset, then WIDTH=8, a=0x3C, b=0x0F, cin=0, out_ready=1 → in_ready drops the cycle after accept; out_valid after 8 RUN cycles with sum=0x4B, cout=0, ovf=0; back in IDLE one cycle later.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum, cout and ovf stay constant and in_ready stays 0. A new in_valid pulse in that window is not accepted. Raising out_ready returns the block to IDLE, and the next operand pair is then accepted.
- Reset mid-RUN: assert rst_n=0 asynchronously after 3 RUN cycles of a=0xAA, b=0x55 → outputs clear immediately with no clock. After release, a=0x01, b=0x02 gives sum=0x03 with no residue from the aborted operation.
- Back-to-back throughput: in_valid and out_ready held high with 16 random operand pairs → every result equals (a+b+cin) mod 256, with the correct cout and ovf, and accepts are spaced exactly WIDTH+2 cycles apart.
